// File: rtl/sgdmac_pkg.sv
// rtl/sgdmac_pkg.sv - shared types and pointer helpers for the SG-DMA read buffer
package sgdmac_pkg;

    localparam int RD_DATA_W = 32;

    typedef struct packed {
        logic                 last;
        logic [RD_DATA_W-1:0] data;
    } rd_beat_t;

    // Pointers carry one extra wrap bit above the address bits.
    function automatic int ptr_w(input int depth_lg2);
        return depth_lg2 + 1;
    endfunction

    function automatic int fifo_depth(input int depth_lg2);
        return 1 << depth_lg2;
    endfunction

endpackage

// File: rtl/sgdmac_rd_buffer_mem.sv
// rtl/sgdmac_rd_buffer_mem.sv - register array with one write port and one asynchronous read port
module sgdmac_rd_buffer_mem #(
    parameter int WIDTH  = 33,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [1<<ADDR_W];

    // Contents are qualified by the pointers, so the array itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sgdmac_rd_buffer.sv
// rtl/sgdmac_rd_buffer.sv - first-word fall-through elastic FIFO on the SG-DMA read-memory channel
module sgdmac_rd_buffer
    import sgdmac_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int DEPTH_LG2    = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [DATA_SIZE-1:0] s_data_i,
    input  logic                 s_last_i,
    output logic                 rm_valid_o,
    input  logic                 rm_ready_i,
    output logic [DATA_SIZE-1:0] rm_data_o,
    output logic                 rm_last_o,
    input  logic                 flush_i,
    output logic [DEPTH_LG2:0]   count_o,
    output logic                 afull_o,
    output logic [DEPTH_LG2:0]   burst_cnt_o
);

    localparam int PW = ptr_w(DEPTH_LG2);

    typedef struct packed {
        logic                 last;
        logic [DATA_SIZE-1:0] data;
    } beat_t;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count_q;
    logic [PW-1:0] burst_q;
    logic          ready_en;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          burst_inc;
    logic          burst_dec;
    beat_t         wr_beat;
    beat_t         rd_beat;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);

    // ready_en stays low while rst is high and comes up on the first edge after release.
    assign s_ready_o  = ~full & ~flush_i & ready_en;
    assign rm_valid_o = ~empty;

    assign push      = s_valid_i & s_ready_o;
    assign pop       = rm_valid_o & rm_ready_i & ~flush_i;
    assign burst_inc = push & s_last_i;
    assign burst_dec = pop & rm_last_o;

    assign wr_beat.last = s_last_i;
    assign wr_beat.data = s_data_i;

    sgdmac_rd_buffer_mem #(
        .WIDTH  (DATA_SIZE + 1),
        .ADDR_W (DEPTH_LG2)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[PW-2:0]),
        .wdata (wr_beat),
        .raddr (rd_ptr[PW-2:0]),
        .rdata (rd_beat)
    );

    assign rm_data_o = rd_beat.data;
    assign rm_last_o = rd_beat.last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            burst_q  <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (flush_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
                burst_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
                case ({burst_inc, burst_dec})
                    2'b10:   burst_q <= burst_q + 1'b1;
                    2'b01:   burst_q <= burst_q - 1'b1;
                    default: burst_q <= burst_q;
                endcase
            end
        end
    end

    assign count_o     = count_q;
    assign burst_cnt_o = burst_q;
    // Gated by ready_en so a zero threshold still reads deasserted in reset.
    assign afull_o     = ready_en & (count_q >= PW'(AFULL_THRESH));

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
    a_count_ptrs:   assert property (@(posedge clk) disable iff (rst) count_q == PW'(wr_ptr - rd_ptr));
    a_burst_le_cnt: assert property (@(posedge clk) disable iff (rst) burst_q <= count_q);

endmodule

// File: tb/tb_sgdmac_rd_buffer.sv
// tb/tb_sgdmac_rd_buffer.sv - randomized self-checking bench for sgdmac_rd_buffer against a queue model
module tb_sgdmac_rd_buffer;

    localparam int DW    = 32;
    localparam int LG    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid_i = 1'b0;
    logic          s_ready_o;
    logic [DW-1:0] s_data_i = '0;
    logic          s_last_i = 1'b0;
    logic          rm_valid_o;
    logic          rm_ready_i = 1'b0;
    logic [DW-1:0] rm_data_o;
    logic          rm_last_o;
    logic          flush_i = 1'b0;
    logic [LG:0]   count_o;
    logic          afull_o;
    logic [LG:0]   burst_cnt_o;

    typedef struct {
        logic          last;
        logic [DW-1:0] data;
    } beat_s;

    beat_s q[$];
    bit    up = 1'b0;
    int    checks = 0;
    int    errors = 0;

    sgdmac_rd_buffer #(
        .DATA_SIZE    (DW),
        .DEPTH_LG2    (LG),
        .AFULL_THRESH (AF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data_i),
        .s_last_i    (s_last_i),
        .rm_valid_o  (rm_valid_o),
        .rm_ready_i  (rm_ready_i),
        .rm_data_o   (rm_data_o),
        .rm_last_o   (rm_last_o),
        .flush_i     (flush_i),
        .count_o     (count_o),
        .afull_o     (afull_o),
        .burst_cnt_o (burst_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs();
        int bursts = 0;
        foreach (q[i]) if (q[i].last) bursts++;
        check("rm_valid", rm_valid_o, 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("rm_data", rm_data_o, q[0].data);
            check("rm_last", rm_last_o, q[0].last);
        end
        check("count", count_o, 64'(q.size()));
        check("afull", afull_o, 64'(q.size() >= AF));
        check("burst_cnt", burst_cnt_o, 64'(bursts));
    endtask

    // Drive one cycle of inputs, predict the handshake, advance the model across the edge.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l, input bit r, input bit f);
        bit exp_rdy;
        bit push;
        bit pop;
        s_valid_i  = v;
        s_data_i   = d;
        s_last_i   = l;
        rm_ready_i = r;
        flush_i    = f;
        #1;
        exp_rdy = !rst && up && (q.size() < DEPTH) && !f;
        check("s_ready", s_ready_o, 64'(exp_rdy));
        push = v && exp_rdy;
        pop  = r && (q.size() > 0) && !f && !rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            up = 1'b0;
        end else begin
            if (f) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back('{last: l, data: d});
            end
            up = 1'b1;
        end
        @(negedge clk);
        check_outs();
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);

        // Reset held with s_valid_i high.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
            check("rst_ready", s_ready_o, 64'd0);
        end
        rst = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("ready_after_rst", s_ready_o, 64'd1);

        // Fill to full, attempt an overflow push, then drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i + 1), 1'b0, 1'b0, 1'b0);
        check("full_count", count_o, 64'd16);
        cycle(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_data", rm_data_o, 64'(i + 1));
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        check("drained_count", count_o, 64'd0);

        // Steady push+pop at occupancy 5, running the pointers past the wrap.
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(100 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("steady_data", rm_data_o, 64'(100 + i));
            cycle(1'b1, DW'(105 + i), 1'b0, 1'b1, 1'b0);
            check("steady_count", count_o, 64'd5);
        end
        while (q.size() > 0) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Bursts of 4, 1, 6 beats; lasts land on beats 4, 5 and 11.
        for (int i = 0; i < 11; i++) cycle(1'b1, DW'(200 + i), (i == 3 || i == 4 || i == 10), 1'b0, 1'b0);
        check("bursts_stored", burst_cnt_o, 64'd3);
        for (int i = 0; i < 5; i++) begin
            check("pop_last", rm_last_o, 64'(i == 3 || i == 4));
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        check("bursts_left", burst_cnt_o, 64'd1);

        // Flush at count 9 with both handshakes requested.
        while (q.size() > 0) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, DW'($urandom), ($urandom_range(0, 2) == 0), 1'b0, 1'b0);
        cycle(1'b1, 32'h5555, 1'b1, 1'b1, 1'b1);
        flush_i = 1'b0;
        s_valid_i = 1'b0;
        #1;
        check("ready_after_flush", s_ready_o, 64'd1);
        check("count_after_flush", count_o, 64'd0);
        @(negedge clk);

        // Asynchronous reset between edges at count 7.
        for (int i = 0; i < 7; i++) cycle(1'b1, DW'($urandom), ($urandom_range(0, 1) == 0), 1'b0, 1'b0);
        s_valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", rm_valid_o, 64'd0);
        check("arst_count", count_o, 64'd0);
        check("arst_burst", burst_cnt_o, 64'd0);
        check("arst_ready", s_ready_o, 64'd0);
        q.delete();
        up = 1'b0;
        @(negedge clk);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0);
        check("fresh_valid", rm_valid_o, 64'd1);
        check("fresh_data", rm_data_o, 64'hA5);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
            check("burst_le_count", 64'(burst_cnt_o <= count_o), 64'd1);
        end
        while (q.size() > 0) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
